// File: rtl/complex_mul_pipe.sv
// Three-stage pipelined complex multiplier (products, sums, round/saturate) with
// valid/ready flow control and per-sample conjugate and rounding selection.
module complex_mul_pipe #(
    parameter int p_inputWidth    = 8,
    parameter int p_PointPosition = 3,
    parameter int p_outputWidth   = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rstn,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic                            i_conj,
    input  logic                            i_round,
    input  logic signed [p_inputWidth-1:0]  inAr,
    input  logic signed [p_inputWidth-1:0]  inAi,
    input  logic signed [p_inputWidth-1:0]  inBr,
    input  logic signed [p_inputWidth-1:0]  inBi,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic signed [p_outputWidth-1:0] o_ResR,
    output logic signed [p_outputWidth-1:0] o_ResI,
    output logic                            o_ovf
);

    localparam int W  = p_inputWidth;
    localparam int P  = p_PointPosition;
    localparam int OW = p_outputWidth;
    localparam int PW = 2 * W;
    localparam int SW = PW + 1;
    localparam int RW = PW + 2;

    localparam logic signed [RW-1:0] HALF    = RW'(1) << (P - 1);
    localparam logic signed [RW-1:0] SAT_MAX = {{(RW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = {{(RW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    // Widened before the optional half-LSB add so the add can never wrap.
    function automatic logic signed [RW-1:0] round_shift(input logic signed [SW-1:0] x,
                                                         input logic rnd);
        logic signed [RW-1:0] v;
        v = {{(RW-SW){x[SW-1]}}, x};
        if (rnd) v = v + HALF;
        return v >>> P;
    endfunction

    // Returns {clamped, value}.
    function automatic logic [OW:0] saturate(input logic signed [RW-1:0] v);
        logic [OW:0] res;
        if (v > SAT_MAX)      res = {1'b1, SAT_MAX[OW-1:0]};
        else if (v < SAT_MIN) res = {1'b1, SAT_MIN[OW-1:0]};
        else                  res = {1'b0, v[OW-1:0]};
        return res;
    endfunction

    logic                 r_vld_p1, r_vld_p2, r_vld_p3;
    logic                 r_conj_p1, r_round_p1, r_round_p2;
    logic signed [PW-1:0] r_prr_p1, r_pii_p1, r_pri_p1, r_pir_p1;
    logic signed [SW-1:0] r_re_p2, r_im_p2;
    logic signed [OW-1:0] r_res_r_p3, r_res_i_p3;
    logic                 r_ovf_p3;

    logic                 w_ld1, w_ld2, w_ld3;
    logic signed [PW-1:0] w_ar, w_ai, w_br, w_bi;
    logic signed [SW-1:0] w_xrr, w_xii, w_xri, w_xir, w_sum_re, w_sum_im;
    logic        [OW:0]   w_sat_re, w_sat_im;

    // A stage may load when it is empty or its contents move on this cycle.
    assign w_ld3   = ~r_vld_p3 | i_ready;
    assign w_ld2   = ~r_vld_p2 | w_ld3;
    assign w_ld1   = ~r_vld_p1 | w_ld2;
    assign o_ready = w_ld1;

    assign w_ar = {{W{inAr[W-1]}}, inAr};
    assign w_ai = {{W{inAi[W-1]}}, inAi};
    assign w_br = {{W{inBr[W-1]}}, inBr};
    assign w_bi = {{W{inBi[W-1]}}, inBi};

    assign w_xrr = {r_prr_p1[PW-1], r_prr_p1};
    assign w_xii = {r_pii_p1[PW-1], r_pii_p1};
    assign w_xri = {r_pri_p1[PW-1], r_pri_p1};
    assign w_xir = {r_pir_p1[PW-1], r_pir_p1};
    assign w_sum_re = r_conj_p1 ? (w_xrr + w_xii) : (w_xrr - w_xii);
    assign w_sum_im = r_conj_p1 ? (w_xir - w_xri) : (w_xri + w_xir);

    assign w_sat_re = saturate(round_shift(r_re_p2, r_round_p2));
    assign w_sat_im = saturate(round_shift(r_im_p2, r_round_p2));

    // Stage 1 / stage 2 data registers
    always_ff @(posedge i_clk) begin
        if (w_ld1 && i_valid) begin
            r_prr_p1   <= w_ar * w_br;
            r_pii_p1   <= w_ai * w_bi;
            r_pri_p1   <= w_ar * w_bi;
            r_pir_p1   <= w_ai * w_br;
            r_conj_p1  <= i_conj;
            r_round_p1 <= i_round;
        end
        if (w_ld2 && r_vld_p1) begin
            r_re_p2    <= w_sum_re;
            r_im_p2    <= w_sum_im;
            r_round_p2 <= r_round_p1;
        end
    end

    // Stage valids and stage 3 output register
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_vld_p1   <= 1'b0;
            r_vld_p2   <= 1'b0;
            r_vld_p3   <= 1'b0;
            r_res_r_p3 <= '0;
            r_res_i_p3 <= '0;
            r_ovf_p3   <= 1'b0;
        end else begin
            if (w_ld1) r_vld_p1 <= i_valid;
            if (w_ld2) r_vld_p2 <= r_vld_p1;
            if (w_ld3) begin
                r_vld_p3 <= r_vld_p2;
                if (r_vld_p2) begin
                    r_res_r_p3 <= w_sat_re[OW-1:0];
                    r_res_i_p3 <= w_sat_im[OW-1:0];
                    r_ovf_p3   <= w_sat_re[OW] | w_sat_im[OW];
                end
            end
        end
    end

    assign o_valid = r_vld_p3;
    assign o_ResR  = r_res_r_p3;
    assign o_ResI  = r_res_i_p3;
    assign o_ovf   = r_ovf_p3;

endmodule

// File: tb/tb_complex_mul_pipe.sv
// Bench for complex_mul_pipe: integer reference model with an in-order scoreboard,
// plus directed literal cases, stall patterns and mid-stream reset.
module tb_complex_mul_pipe;

    localparam int W  = 8;
    localparam int P  = 3;
    localparam int OW = 8;

    logic                  clk;
    logic                  i_rstn, i_valid, i_conj, i_round, i_ready;
    logic signed [W-1:0]   inAr, inAi, inBr, inBi;
    logic                  o_ready, o_valid, o_ovf;
    logic signed [OW-1:0]  o_ResR, o_ResI;

    complex_mul_pipe #(
        .p_inputWidth(W), .p_PointPosition(P), .p_outputWidth(OW)
    ) dut (
        .i_clk(clk), .i_rstn(i_rstn), .i_valid(i_valid), .o_ready(o_ready),
        .i_conj(i_conj), .i_round(i_round),
        .inAr(inAr), .inAi(inAi), .inBr(inBr), .inBi(inBi),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_ResR(o_ResR), .o_ResI(o_ResI), .o_ovf(o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int re;
        int im;
        int ovf;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int floor_div(input int x, input int d);
        int r;
        r = x / d;
        if ((x % d) != 0 && x < 0) r = r - 1;
        return r;
    endfunction

    function automatic int clamp(input int v, inout int ovf);
        int hi, lo;
        hi = (1 << (OW - 1)) - 1;
        lo = -(1 << (OW - 1));
        if (v > hi) begin ovf = 1; return hi; end
        if (v < lo) begin ovf = 1; return lo; end
        return v;
    endfunction

    function automatic exp_t model(input int ar, input int ai, input int br, input int bi,
                                   input bit conj, input bit rnd);
        exp_t e;
        int   re, im, half, ovf;
        re   = conj ? (ar * br + ai * bi) : (ar * br - ai * bi);
        im   = conj ? (ai * br - ar * bi) : (ar * bi + ai * br);
        half = rnd ? (1 << (P - 1)) : 0;
        ovf  = 0;
        e.re  = clamp(floor_div(re + half, 1 << P), ovf);
        e.im  = clamp(floor_div(im + half, 1 << P), ovf);
        e.ovf = ovf;
        return e;
    endfunction

    // Scoreboard: evaluated mid-cycle, describing the transfers of the coming edge.
    bit hold_v = 0;
    int hold_re, hold_im, hold_ovf;
    always @(negedge clk) begin
        exp_t e;
        if (!i_rstn) begin
            q.delete();
            hold_v = 0;
        end else begin
            chk("o_ready", int'(o_ready), int'(!(q.size() == 3 && !i_ready)));
            if (hold_v) begin
                chk("stall_valid", int'(o_valid), 1);
                chk("stall_re", int'(o_ResR), hold_re);
                chk("stall_im", int'(o_ResI), hold_im);
                chk("stall_ovf", int'(o_ovf), hold_ovf);
            end
            hold_v   = o_valid && !i_ready;
            hold_re  = int'(o_ResR);
            hold_im  = int'(o_ResI);
            hold_ovf = int'(o_ovf);
            if (o_valid && i_ready) begin
                if (q.size() == 0) chk("spurious_output", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("model_re", int'(o_ResR), e.re);
                    chk("model_im", int'(o_ResI), e.im);
                    chk("model_ovf", int'(o_ovf), e.ovf);
                end
            end
            if (i_valid && o_ready)
                q.push_back(model(int'(inAr), int'(inAi), int'(inBr), int'(inBi),
                                  i_conj, i_round));
        end
    end

    function automatic logic signed [W-1:0] rand_op();
        logic signed [W-1:0] v;
        v = W'($urandom_range(0, (1 << W) - 1));
        if ($urandom_range(0, 7) == 0) v = {1'b1, {(W-1){1'b0}}};
        return v;
    endfunction

    task automatic set_rand_data();
        inAr    = rand_op();
        inAi    = rand_op();
        inBr    = rand_op();
        inBi    = rand_op();
        i_conj  = 1'($urandom_range(0, 1));
        i_round = 1'($urandom_range(0, 1));
    endtask

    task automatic send_one(input string name, input int ar, input int ai, input int br,
                            input int bi, input bit conj, input bit rnd,
                            input int exp_re, input int exp_im, input int exp_ovf);
        int lat;
        @(posedge clk); #1;
        inAr = W'(ar); inAi = W'(ai); inBr = W'(br); inBi = W'(bi);
        i_conj = conj; i_round = rnd; i_valid = 1'b1; i_ready = 1'b1;
        lat = 0;
        while (lat < 10) begin
            @(posedge clk); #1;
            i_valid = 1'b0;
            lat++;
            if (o_valid) break;
        end
        chk({name, "_latency"}, lat, 3);
        chk({name, "_re"}, int'(o_ResR), exp_re);
        chk({name, "_im"}, int'(o_ResI), exp_im);
        chk({name, "_ovf"}, int'(o_ovf), exp_ovf);
    endtask

    task automatic run_stream(input string name, input int n, input bit rnd_mode);
        int sent, cyc;
        bit acc;
        sent = 0;
        cyc  = 0;
        @(posedge clk); #1;
        while (sent < n && cyc < 5000) begin
            i_valid = rnd_mode ? ($urandom_range(0, 9) < 7) : 1'b1;
            i_ready = rnd_mode ? ($urandom_range(0, 9) < 6) : ((cyc % 4) == 0 || (cyc % 4) == 3);
            set_rand_data();
            @(negedge clk);
            acc = i_valid && o_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        chk({name, "_sent"}, sent, n);
        repeat (8) @(posedge clk);
        #1;
        chk({name, "_drained"}, q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d of %0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        i_rstn = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_conj = 1'b0; i_round = 1'b0;
        inAr = '0; inAi = '0; inBr = '0; inBi = '0;
        repeat (2) @(posedge clk);
        #1;
        i_rstn = 1'b1;
        chk("reset_valid", int'(o_valid), 0);
        chk("reset_re", int'(o_ResR), 0);
        chk("reset_im", int'(o_ResI), 0);
        chk("reset_ovf", int'(o_ovf), 0);
        chk("reset_ready", int'(o_ready), 1);

        send_one("unity_mul", 8, 8, 8, 8, 1'b0, 1'b0, 0, 16, 0);
        send_one("unity_conj", 8, 8, 8, 8, 1'b1, 1'b0, 16, 0, 0);
        send_one("trunc_pos", 1, 0, 4, 0, 1'b0, 1'b0, 0, 0, 0);
        send_one("round_pos", 1, 0, 4, 0, 1'b0, 1'b1, 1, 0, 0);
        send_one("trunc_neg", 1, 0, -4, 0, 1'b0, 1'b0, -1, 0, 0);
        send_one("round_neg", 1, 0, -4, 0, 1'b0, 1'b1, 0, 0, 0);
        send_one("sat_pos", -128, 0, -128, 0, 1'b0, 1'b0, 127, 0, 1);
        send_one("sat_neg", -128, 0, 127, 0, 1'b0, 1'b0, -128, 0, 1);

        run_stream("toggle", 10, 1'b0);
        run_stream("random", 300, 1'b1);

        // Fill the pipe while stalled, then reset with three samples in flight.
        @(posedge clk); #1;
        i_ready = 1'b0;
        i_valid = 1'b1;
        repeat (3) begin
            set_rand_data();
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        chk("full_valid", int'(o_valid), 1);
        chk("full_ready", int'(o_ready), 0);
        i_rstn = 1'b0;
        @(posedge clk); #1;
        i_rstn = 1'b1;
        chk("midrst_valid", int'(o_valid), 0);
        chk("midrst_re", int'(o_ResR), 0);
        chk("midrst_im", int'(o_ResI), 0);
        chk("midrst_ovf", int'(o_ovf), 0);
        chk("midrst_ready", int'(o_ready), 1);
        i_ready = 1'b1;
        send_one("after_rst", 8, 8, 8, 8, 1'b0, 1'b0, 0, 16, 0);
        repeat (6) @(posedge clk);
        #1;
        chk("final_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
